regfile_write_checker: RTL

REGFILE_WRITE_CHECKER -- requirements
Module: regfile_write_checker

---
 rtl/chk_pkg.sv | 23 ++
 rtl/chk_exp_fifo.sv | 59 +++++
 rtl/regfile_write_checker.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chk_pkg
// Description : Shared FSM state encoding and default parameter constants for
//               the register-file write checker.
// Revision    : 1.0 - initial release
// ============================================================================
package chk_pkg;

    localparam int c_data_width     = 32;
    localparam int c_reg_addr_width = 5;
    localparam int c_exp_depth      = 16;
    localparam int c_timeout_cycles = 4000;
    localparam int c_err_width      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/chk_exp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : chk_exp_fifo
// Description : Expected-write table. Entries are appended at a write pointer
//               and read back randomly by index; full when DEPTH entries held.
// Revision    : 1.0 - initial release
// ============================================================================
module chk_exp_fifo
    import chk_pkg::*;
#(
    parameter int DEPTH          = c_exp_depth,
    parameter int DATA_WIDTH     = c_data_width,
    parameter int REG_ADDR_WIDTH = c_reg_addr_width
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clr,
    input  logic                         push,
    input  logic [REG_ADDR_WIDTH-1:0]    push_reg,
    input  logic [DATA_WIDTH-1:0]        push_data,
    input  logic [$clog2(DEPTH)-1:0]     rd_idx,
    output logic [REG_ADDR_WIDTH-1:0]    rd_reg,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int ENT_W = REG_ADDR_WIDTH + DATA_WIDTH;

    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;

    // Storage has no reset: an empty table is defined by the count alone.
    always_ff @(posedge clock) begin
        if (push && !full) begin
            r_mem[r_count[IDX_W-1:0]] <= {push_reg, push_data};
        end
    end

    // Write pointer / occupancy count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (push && !full) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign full    = (r_count == CNT_W'(DEPTH));
    assign count   = r_count;
    assign rd_reg  = r_mem[rd_idx][ENT_W-1:DATA_WIDTH];
    assign rd_data = r_mem[rd_idx][DATA_WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/regfile_write_checker.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_checker
// Description : Loads a table of expected register-file writes, then watches
//               the write port and compares each non-r0 write in order,
//               reporting errors, timeout, overflow and a registered pass flag.
//               Optional macro CHECKER_FIRST_MISMATCH_EN adds first-mismatch
//               index capture (first_bad_valid / first_bad_idx).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_checker
    import chk_pkg::*;
#(
    parameter int DATA_WIDTH     = c_data_width,
    parameter int REG_ADDR_WIDTH = c_reg_addr_width,
    parameter int EXP_DEPTH      = c_exp_depth,
    parameter int TIMEOUT_CYCLES = c_timeout_cycles,
    parameter int ERR_WIDTH      = c_err_width
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          load_en,
    input  logic [REG_ADDR_WIDTH-1:0]     load_reg,
    input  logic [DATA_WIDTH-1:0]         load_data,
    input  logic                          start,
    input  logic                          clear,
    input  logic                          ctrl_writeEnable,
    input  logic [REG_ADDR_WIDTH-1:0]     ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0]         data_writeReg,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic                          timeout,
    output logic                          overflow,
    output logic [ERR_WIDTH-1:0]          errors,
    output logic [$clog2(EXP_DEPTH):0]    exp_count
`ifdef CHECKER_FIRST_MISMATCH_EN
    ,
    output logic                          first_bad_valid,
    output logic [$clog2(EXP_DEPTH)-1:0]  first_bad_idx
`endif
);

    localparam int IDX_W = $clog2(EXP_DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int CYC_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CYC_W-1:0]     c_cyc_last = CYC_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ERR_WIDTH-1:0] c_err_max  = '1;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [CNT_W-1:0]          r_idx;
    logic [CYC_W-1:0]          r_cyc;
    logic [ERR_WIDTH-1:0]      r_errors;
    logic [ERR_WIDTH-1:0]      w_errors_nxt;
    logic [ERR_WIDTH-1:0]      w_errors_inc;
    logic                      r_timeout;
    logic                      w_timeout_nxt;
    logic                      r_overflow;
    logic                      r_pass;
    logic                      w_obs;
    logic                      w_mismatch;
    logic                      w_last;
    logic                      w_push;
    logic                      w_full;
    logic [CNT_W-1:0]          w_count;
    logic [REG_ADDR_WIDTH-1:0] w_exp_reg;
    logic [DATA_WIDTH-1:0]     w_exp_data;

    chk_exp_fifo #(
        .DEPTH          (EXP_DEPTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_exp_fifo (
        .clock     (clock),
        .reset     (reset),
        .clr       (clear),
        .push      (w_push),
        .push_reg  (load_reg),
        .push_data (load_data),
        .rd_idx    (r_idx[IDX_W-1:0]),
        .rd_reg    (w_exp_reg),
        .rd_data   (w_exp_data),
        .count     (w_count),
        .full      (w_full)
    );

    assign w_push = (r_state == IDLE) && !clear && load_en && !w_full;

    // Next-state, error and timeout decisions for the checker FSM.
    always_comb begin
        w_obs         = ctrl_writeEnable && (ctrl_writeReg != '0);
        w_mismatch    = w_obs && ((w_exp_reg != ctrl_writeReg) ||
                                  (w_exp_data != data_writeReg));
        w_last        = (r_idx == (w_count - CNT_W'(1)));
        w_errors_inc  = (r_errors == c_err_max) ? r_errors
                                                : r_errors + ERR_WIDTH'(1);
        w_state_nxt   = r_state;
        w_errors_nxt  = r_errors;
        w_timeout_nxt = r_timeout;
        if (clear) begin
            w_state_nxt   = IDLE;
            w_errors_nxt  = '0;
            w_timeout_nxt = 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        w_state_nxt = (w_count == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (w_mismatch) begin
                        w_errors_nxt = w_errors_inc;
                    end
                    // A last-entry write wins over a coincident timeout.
                    if (w_obs && w_last) begin
                        w_state_nxt = DONE;
                    end else if (r_cyc == c_cyc_last) begin
                        w_state_nxt   = DONE;
                        w_timeout_nxt = 1'b1;
                    end
                end
                DONE: begin
                    if (w_obs) begin
                        w_errors_nxt = w_errors_inc;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // FSM state plus registered status outputs, index and cycle counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_errors   <= '0;
            r_timeout  <= 1'b0;
            r_pass     <= 1'b0;
            r_overflow <= 1'b0;
            r_idx      <= '0;
            r_cyc      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_errors  <= w_errors_nxt;
            r_timeout <= w_timeout_nxt;
            r_pass    <= (w_state_nxt == DONE) && (w_errors_nxt == '0) &&
                         !w_timeout_nxt;
            if (clear) begin
                r_overflow <= 1'b0;
                r_idx      <= '0;
                r_cyc      <= '0;
            end else begin
                if ((r_state == IDLE) && load_en && w_full) begin
                    r_overflow <= 1'b1;
                end
                if ((r_state == IDLE) && start) begin
                    r_idx <= '0;
                    r_cyc <= '0;
                end
                if (r_state == RUN) begin
                    r_cyc <= r_cyc + CYC_W'(1);
                    if (w_obs) begin
                        r_idx <= r_idx + CNT_W'(1);
                    end
                end
            end
        end
    end

`ifdef CHECKER_FIRST_MISMATCH_EN
    logic             r_first_bad_valid;
    logic [IDX_W-1:0] r_first_bad_idx;

    // Latch the table index of the first mismatching write in a run.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_first_bad_valid <= 1'b0;
            r_first_bad_idx   <= '0;
        end else if (clear) begin
            r_first_bad_valid <= 1'b0;
            r_first_bad_idx   <= '0;
        end else if ((r_state == RUN) && w_mismatch && !r_first_bad_valid) begin
            r_first_bad_valid <= 1'b1;
            r_first_bad_idx   <= r_idx[IDX_W-1:0];
        end
    end

    assign first_bad_valid = r_first_bad_valid;
    assign first_bad_idx   = r_first_bad_idx;
`endif

    assign busy      = (r_state == RUN);
    assign done      = (r_state == DONE);
    assign pass      = r_pass;
    assign timeout   = r_timeout;
    assign overflow  = r_overflow;
    assign errors    = r_errors;
    assign exp_count = w_count;

endmodule
`default_nettype wire
